// File: rtl/collision_tracker.sv
// collision_tracker: frame-synchronous player/obstacle collision detector
// with per-obstacle mask, first-hit capture and saturating frame counter.
module collision_tracker #(
  parameter int N_OBJ        = 8,
  parameter int SCREEN_CORDW = 16,
  parameter int CNT_W        = 8,
  parameter int STICKY       = 0,
  localparam int IDXW        = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                           clk_pix,
  input  logic                           reset_n,
  input  logic                           frame,
  input  logic                           de,
  input  logic signed [SCREEN_CORDW-1:0] screen_x,
  input  logic signed [SCREEN_CORDW-1:0] screen_y,
  input  logic                           player_drawing,
  input  logic [N_OBJ-1:0]               obj_drawing,
  input  logic                           clear,
  output logic [N_OBJ-1:0]               hit_mask,
  output logic                           hit_any,
  output logic                           hit_pulse,
  output logic [IDXW-1:0]                first_idx,
  output logic [SCREEN_CORDW-1:0]        first_x,
  output logic [SCREEN_CORDW-1:0]        first_y,
  output logic [CNT_W-1:0]               hit_count
);

  logic [N_OBJ-1:0]        hv;
  logic                    hv_any;
  logic [IDXW-1:0]         low_idx;
  logic [N_OBJ-1:0]        acc;
  logic                    cap_valid;
  logic [IDXW-1:0]         cap_idx;
  logic [SCREEN_CORDW-1:0] cap_x;
  logic [SCREEN_CORDW-1:0] cap_y;
  logic [N_OBJ-1:0]        mask_next;

  assign hv     = (de && player_drawing) ? obj_drawing : '0;
  assign hv_any = |hv;

  always_comb begin
    low_idx = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hv[i]) low_idx = IDXW'(i);
    end
  end

  assign mask_next = (STICKY != 0) ? (hit_mask | acc) : acc;

  // Accumulator and first-hit capture; frame pixel opens the new frame
  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      cap_valid <= 1'b0;
      cap_idx   <= '0;
      cap_x     <= '0;
      cap_y     <= '0;
    end else if (frame) begin
      acc       <= hv;
      cap_valid <= hv_any;
      if (hv_any) begin
        cap_idx <= low_idx;
        cap_x   <= screen_x;
        cap_y   <= screen_y;
      end
    end else begin
      acc <= acc | hv;
      if (!cap_valid && hv_any) begin
        cap_valid <= 1'b1;
        cap_idx   <= low_idx;
        cap_x     <= screen_x;
        cap_y     <= screen_y;
      end
    end
  end

  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) begin
      hit_mask  <= '0;
      hit_any   <= 1'b0;
      hit_pulse <= 1'b0;
      first_idx <= '0;
      first_x   <= '0;
      first_y   <= '0;
      hit_count <= '0;
    end else if (clear) begin
      hit_mask  <= '0;
      hit_any   <= 1'b0;
      hit_pulse <= 1'b0;
      first_idx <= '0;
      first_x   <= '0;
      first_y   <= '0;
      hit_count <= '0;
    end else if (frame) begin
      hit_mask  <= mask_next;
      hit_any   <= |mask_next;
      hit_pulse <= |(mask_next & ~hit_mask);
      if (cap_valid) begin
        first_idx <= cap_idx;
        first_x   <= cap_x;
        first_y   <= cap_y;
      end else if (STICKY == 0) begin
        first_idx <= '0;
        first_x   <= '0;
        first_y   <= '0;
      end
      if ((|acc) && (hit_count != {CNT_W{1'b1}})) begin
        hit_count <= hit_count + 1'b1;
      end
    end else begin
      hit_pulse <= 1'b0;
    end
  end

endmodule
